mpu_user_fifo: RTL

- Downstream consumer of the MPU user-event channel: `mpu_top` raises `user_irq` with a 64-bit `user_data` word.
- This block buffers those words in a FIFO and back-pressures the MPU through `en`.
- It drains the words to a host-side reader with pop/valid handshake.
- It raises a host interrupt on a fill threshold or an idle timeout.
- It replaces the simulation-only user interrupt stub in the MPU subsystem.

---
 rtl/mpu_pkg.sv | 10 +
 rtl/mpu_user_fifo_if.sv | 26 ++
 rtl/mpu_fifo_ram.sv | 24 ++
 rtl/mpu_user_fifo.sv | 69 ++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared constants and helpers for the MPU user-event channel.
package mpu_pkg;
   localparam int MPU_USER_W = 64;
   localparam int DEF_DEPTH_LOG2 = 4;
   localparam int DEF_THRESHOLD = 8;
   localparam int DEF_TIMEOUT = 255;
   function automatic int level_w(input int depth_log2);
      return depth_log2 + 1;
   endfunction
endpackage

// File: rtl/mpu_user_fifo_if.sv
// mpu_user_fifo_if: MPU push side plus host pop side of the user-event FIFO.
interface mpu_user_fifo_if
   import mpu_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
);
   logic                          irq;
   logic [MPU_USER_W-1:0]         data;
   logic                          en;
   logic                          rd;
   logic [MPU_USER_W-1:0]         rd_data;
   logic                          rd_valid;
   logic [level_w(DEPTH_LOG2)-1:0] level;
   logic                          empty;
   logic                          overflow;
   logic                          ovf_clr;
   logic                          host_irq;
   modport slave (
      input  irq, data, rd, ovf_clr,
      output en, rd_data, rd_valid, level, empty, overflow, host_irq
   );
   modport master (
      output irq, data, rd, ovf_clr,
      input  en, rd_data, rd_valid, level, empty, overflow, host_irq
   );
endinterface

// File: rtl/mpu_fifo_ram.sv
// mpu_fifo_ram: simple dual-port RAM with a registered read port.
module mpu_fifo_ram #(
   parameter int AW = 4,
   parameter int W = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   // rdata holds between reads; a same-address write returns the old word
   always_ff @(posedge clk) begin
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/mpu_user_fifo.sv
// mpu_user_fifo: buffers MPU user events, back-pressures the MPU via en,
// drains to the host with pop/valid and raises host_irq on fill or idle.
module mpu_user_fifo
   import mpu_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic sys_clk,
   input logic sys_rst,
   mpu_user_fifo_if.slave bus
);
   localparam int LW = level_w(DEPTH_LOG2);
   localparam logic [LW-1:0] DEPTH_L = LW'(2 ** DEPTH_LOG2);
   localparam logic [LW-1:0] THRESH_L = LW'(THRESHOLD);
   localparam logic [15:0] TO = 16'(TIMEOUT);
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count, next_count;
   logic [15:0] timer;
   logic tflag, tflag_nxt, pop_ok, push_ok;
   logic en_q, rd_valid_q, overflow_q, host_irq_q;
   always_comb begin
      pop_ok = bus.rd && (count != '0);
      push_ok = bus.irq && ((count != DEPTH_L) || pop_ok);
      next_count = count + LW'(push_ok) - LW'(pop_ok);
      tflag_nxt = (next_count != '0) && (tflag || (timer == TO && count != '0));
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         en_q <= 1'b1;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         host_irq_q <= 1'b0;
         timer <= '0;
         tflag <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + DEPTH_LOG2'(push_ok);
         rd_ptr <= rd_ptr + DEPTH_LOG2'(pop_ok);
         count <= next_count;
         // one in-flight push still fits in the last slot after en falls
         en_q <= next_count < DEPTH_L - LW'(1);
         rd_valid_q <= pop_ok;
         overflow_q <= (bus.irq && !push_ok) || (overflow_q && !bus.ovf_clr);
         host_irq_q <= (next_count >= THRESH_L) || tflag_nxt;
         timer <= (push_ok || count == '0) ? '0 : (timer == TO) ? timer : timer + 16'd1;
         tflag <= tflag_nxt;
      end
   end
   mpu_fifo_ram #(.AW(DEPTH_LOG2), .W(MPU_USER_W)) u_ram (
      .clk(sys_clk),
      .rst(sys_rst),
      .we(push_ok),
      .waddr(wr_ptr),
      .wdata(bus.data),
      .re(pop_ok),
      .raddr(rd_ptr),
      .rdata(bus.rd_data)
   );
   assign bus.en = en_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.level = count;
   assign bus.empty = count == '0;
   assign bus.overflow = overflow_q;
   assign bus.host_irq = host_irq_q;
endmodule
